// File: rtl/dmvm_scheduler_pkg.sv
// Shared definitions for the DMVM scheduler slice.
//   sched_state_e     : run-control FSM states
//   WH_FLAG_BIT       : WH word bit that marks a subgraph header entry
//   WH_NN_LSB         : low bit of the num_node field in a WH word
//   COEF_FF_DEPTH_DEF : default coefficient FIFO depth (credit pool size)
package dmvm_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } sched_state_e;

  localparam int unsigned WH_FLAG_BIT       = 0;
  localparam int unsigned WH_NN_LSB         = 1;
  localparam int unsigned COEF_FF_DEPTH_DEF = 256;

endpackage

// File: rtl/dmvm_scheduler_credit.sv
// Credit counter tracking free slots in the downstream coefficient FIFO.
//   clk, rst_n : clock, asynchronous active-low reset (count restores to DEPTH)
//   inc_i      : one slot freed (consumer pop)
//   dec_i      : one slot claimed (WH read issued)
//   avail_o    : at least one credit remains
module credit_counter #(
  parameter int unsigned DEPTH = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc_i,
  input  logic dec_i,
  output logic avail_o
);

  localparam int unsigned   CW      = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [CW-1:0] count_q, count_d;
  logic          dec_ok, inc_ok;

  always_comb begin
    dec_ok  = dec_i && (count_q != '0);
    // A pop at a full pool is only meaningful when paired with a claim.
    inc_ok  = inc_i && ((count_q != DEPTH_C) || dec_ok);
    count_d = count_q;
    if (inc_ok && !dec_ok) begin
      count_d = count_q + CW'(1);
    end else if (dec_ok && !inc_ok) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= DEPTH_C;
    end else begin
      count_q <= count_d;
    end
  end

  assign avail_o = (count_q != '0);

endmodule

// File: rtl/dmvm_scheduler.sv
// DMVM scheduler: streams WH entries out of BRAM into the DMVM engine,
// throttled by upstream fill level, coef FIFO credits and num_node FIFO
// back-pressure, then waits for every coefficient to complete.
//   start_i / busy_o / done_o            : run control
//   wh_wr_cnt_i                          : entries already written upstream
//   wh_rd_en_o, wh_addr_o, wh_dout_i     : WH BRAM read port (1-cycle latency)
//   dmvm_vld_o, dmvm_rdy_i               : DMVM input valid / per-coef done
//   coef_ff_rd_i                         : coef FIFO pop (returns a credit)
//   nn_ff_din_o, nn_ff_wr_vld_o, nn_ff_full_i : num_node FIFO write port
module dmvm_scheduler
  import dmvm_scheduler_pkg::*;
#(
  parameter int unsigned TOTAL_NODES    = 13264,
  parameter int unsigned NUM_NODE_WIDTH = 8,
  parameter int unsigned WH_WIDTH       = 201,
  parameter int unsigned COEF_FF_DEPTH  = COEF_FF_DEPTH_DEF,
  parameter int unsigned WH_ADDR_W      = $clog2(TOTAL_NODES)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_i,
  input  logic [WH_ADDR_W:0]        wh_wr_cnt_i,
  output logic                      wh_rd_en_o,
  output logic [WH_ADDR_W-1:0]      wh_addr_o,
  input  logic [WH_WIDTH-1:0]       wh_dout_i,
  output logic                      dmvm_vld_o,
  input  logic                      dmvm_rdy_i,
  input  logic                      coef_ff_rd_i,
  output logic [NUM_NODE_WIDTH-1:0] nn_ff_din_o,
  output logic                      nn_ff_wr_vld_o,
  input  logic                      nn_ff_full_i,
  output logic                      busy_o,
  output logic                      done_o
);

  localparam int unsigned      PTR_W   = WH_ADDR_W + 1;
  localparam logic [PTR_W-1:0] TOTAL_C = PTR_W'(TOTAL_NODES);

  sched_state_e              state_q, state_d;
  logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]          rdy_cnt_q, rdy_cnt_d;
  logic                      vld_q, vld_d;
  logic                      nn_pend_q, nn_pend_d;
  logic [NUM_NODE_WIDTH-1:0] nn_din_q, nn_din_d;

  logic                      rd_en;
  logic                      credit_avail;
  logic                      hdr_now;
  logic                      nn_wr_vld;
  logic [NUM_NODE_WIDTH-1:0] nn_din;
  logic                      unused_wh_bits;

  // Upper WH payload bits feed the DMVM datapath, not this block.
  assign unused_wh_bits = ^wh_dout_i;

  credit_counter #(
    .DEPTH (COEF_FF_DEPTH)
  ) u_credit (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (coef_ff_rd_i),
    .dec_i   (rd_en),
    .avail_o (credit_avail)
  );

  always_comb begin
    // Header handling: a blocked header write is parked and replayed until
    // the FIFO accepts it; reads stay off so no new header can overtake it.
    hdr_now   = vld_q && wh_dout_i[WH_FLAG_BIT];
    nn_wr_vld = nn_pend_q || hdr_now;
    nn_din    = nn_pend_q ? nn_din_q : wh_dout_i[WH_NN_LSB +: NUM_NODE_WIDTH];
    nn_pend_d = nn_wr_vld && nn_ff_full_i;
    nn_din_d  = nn_pend_d ? nn_din : '0;

    rd_en = (state_q == ST_ISSUE) && (rd_ptr_q < TOTAL_C) &&
            (rd_ptr_q < wh_wr_cnt_i) && credit_avail &&
            !nn_ff_full_i && !nn_pend_q;
    vld_d = rd_en;

    rd_ptr_d  = rd_ptr_q;
    rdy_cnt_d = rdy_cnt_q;
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (dmvm_rdy_i && ((state_q == ST_ISSUE) || (state_q == ST_DRAIN))) begin
      rdy_cnt_d = rdy_cnt_q + PTR_W'(1);
    end

    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start_i) state_d = ST_ISSUE;
      ST_ISSUE: if (rd_ptr_q == TOTAL_C) state_d = ST_DRAIN;
      // Looking at the incremented count lets done_o follow the final
      // completion pulse by a single cycle.
      ST_DRAIN: if (rdy_cnt_d == TOTAL_C) state_d = ST_DONE;
      ST_DONE: begin
        state_d   = ST_IDLE;
        rd_ptr_d  = '0;
        rdy_cnt_d = '0;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      rd_ptr_q  <= '0;
      rdy_cnt_q <= '0;
      vld_q     <= 1'b0;
      nn_pend_q <= 1'b0;
      nn_din_q  <= '0;
    end else begin
      state_q   <= state_d;
      rd_ptr_q  <= rd_ptr_d;
      rdy_cnt_q <= rdy_cnt_d;
      vld_q     <= vld_d;
      nn_pend_q <= nn_pend_d;
      nn_din_q  <= nn_din_d;
    end
  end

  assign wh_rd_en_o     = rd_en;
  assign wh_addr_o      = rd_ptr_q[WH_ADDR_W-1:0];
  assign dmvm_vld_o     = vld_q;
  assign nn_ff_wr_vld_o = nn_wr_vld;
  assign nn_ff_din_o    = nn_wr_vld ? nn_din : '0;
  assign busy_o         = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
  assign done_o         = (state_q == ST_DONE);

endmodule

// File: tb/tb_dmvm_scheduler.sv
// Directed self-checking bench for dmvm_scheduler (8 entries, 4 credits).
module tb_dmvm_scheduler;

  localparam int unsigned TN  = 8;
  localparam int unsigned NNW = 8;
  localparam int unsigned WHW = 12;
  localparam int unsigned AW  = 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           start_i = 1'b0;
  logic [AW:0]    wh_wr_cnt_i = '0;
  logic           wh_rd_en_o;
  logic [AW-1:0]  wh_addr_o;
  logic [WHW-1:0] wh_dout_i = '0;
  logic           dmvm_vld_o;
  logic           dmvm_rdy_i = 1'b0;
  logic           coef_ff_rd_i = 1'b0;
  logic [NNW-1:0] nn_ff_din_o;
  logic           nn_ff_wr_vld_o;
  logic           nn_ff_full_i = 1'b0;
  logic           busy_o;
  logic           done_o;

  logic [WHW-1:0] mem [0:TN-1];

  int vectors = 0;
  int miscompares = 0;

  int rd_addr_q[$];
  int rd_cyc_q[$];
  int nn_din_q[$];
  int cyc = 0;
  int vld_cnt = 0;
  int misalign = 0;
  int nn_cyc = 0;
  int done_cnt = 0;
  logic prev_rd = 1'b0;

  dmvm_scheduler #(
    .TOTAL_NODES    (TN),
    .NUM_NODE_WIDTH (NNW),
    .WH_WIDTH       (WHW),
    .COEF_FF_DEPTH  (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_i        (start_i),
    .wh_wr_cnt_i    (wh_wr_cnt_i),
    .wh_rd_en_o     (wh_rd_en_o),
    .wh_addr_o      (wh_addr_o),
    .wh_dout_i      (wh_dout_i),
    .dmvm_vld_o     (dmvm_vld_o),
    .dmvm_rdy_i     (dmvm_rdy_i),
    .coef_ff_rd_i   (coef_ff_rd_i),
    .nn_ff_din_o    (nn_ff_din_o),
    .nn_ff_wr_vld_o (nn_ff_wr_vld_o),
    .nn_ff_full_i   (nn_ff_full_i),
    .busy_o         (busy_o),
    .done_o         (done_o)
  );

  always #5 clk = ~clk;

  // WH BRAM model, 1-cycle read latency.
  always @(posedge clk) begin
    if (wh_rd_en_o) wh_dout_i <= mem[wh_addr_o];
  end

  // Event log sampled mid-cycle, where inputs and outputs are stable.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      prev_rd = 1'b0;
    end else begin
      if (wh_rd_en_o) begin
        rd_addr_q.push_back(int'(wh_addr_o));
        rd_cyc_q.push_back(cyc);
      end
      if (dmvm_vld_o) vld_cnt = vld_cnt + 1;
      if (dmvm_vld_o !== prev_rd) misalign = misalign + 1;
      prev_rd = wh_rd_en_o;
      if (nn_ff_wr_vld_o) nn_cyc = nn_cyc + 1;
      if (nn_ff_wr_vld_o && !nn_ff_full_i) nn_din_q.push_back(int'(nn_ff_din_o));
      if (done_o) done_cnt = done_cnt + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed run still active, expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors = vectors + 1;
    assert (obs === exp) else begin
      miscompares = miscompares + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_en"}, 32'(wh_rd_en_o), 0);
    chk({tag, "_addr"},  32'(wh_addr_o), 0);
    chk({tag, "_vld"},   32'(dmvm_vld_o), 0);
    chk({tag, "_nnwr"},  32'(nn_ff_wr_vld_o), 0);
    chk({tag, "_nndin"}, 32'(nn_ff_din_o), 0);
    chk({tag, "_busy"},  32'(busy_o), 0);
    chk({tag, "_done"},  32'(done_o), 0);
  endtask

  // Eight consecutive completion pulses; done_o must follow the eighth by one cycle.
  task automatic drain(input string tag);
    dmvm_rdy_i = 1'b1;
    repeat (7) tick();
    settle();
    chk({tag, "_done_early"}, 32'(done_o), 0);
    chk({tag, "_busy_drain"}, 32'(busy_o), 1);
    tick();
    dmvm_rdy_i = 1'b0;
    settle();
    chk({tag, "_done"}, 32'(done_o), 1);
    chk({tag, "_busy_done"}, 32'(busy_o), 0);
    tick();
    settle();
    chk({tag, "_done_1cyc"}, 32'(done_o), 0);
    chk({tag, "_idle_rd"}, 32'(wh_rd_en_o), 0);
  endtask

  initial begin
    int rb, vb, nb, cb, db;

    for (int i = 0; i < int'(TN); i++) mem[i] = WHW'((i + 20) << 1);
    mem[0] = WHW'((3 << 1) | 1);
    mem[3] = WHW'((5 << 1) | 1);

    // Reset state
    #2 rst_n = 1'b0;
    repeat (3) tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Completion pulses while idle must not be counted
    dmvm_rdy_i = 1'b1;
    repeat (3) tick();
    dmvm_rdy_i = 1'b0;
    settle();
    chk("idle_rdy_busy", 32'(busy_o), 0);

    // Smoke run with header entries 0 and 3; steady pops keep credits topped up
    rb = rd_addr_q.size(); vb = vld_cnt; nb = nn_din_q.size(); cb = nn_cyc; db = done_cnt;
    wh_wr_cnt_i = 4'd8;
    coef_ff_rd_i = 1'b1;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (10) tick();
    chk("smoke_reads", 32'(rd_addr_q.size() - rb), 8);
    for (int i = 0; i < 8; i++) chk("smoke_addr", 32'(rd_addr_q[rb + i]), 32'(i));
    chk("smoke_consecutive", 32'(rd_cyc_q[rb + 7] - rd_cyc_q[rb]), 7);
    chk("smoke_vld_cnt", 32'(vld_cnt - vb), 8);
    chk("smoke_vld_align", 32'(misalign), 0);
    chk("hdr_count", 32'(nn_din_q.size() - nb), 2);
    chk("hdr_cycles", 32'(nn_cyc - cb), 2);
    chk("hdr_din0", 32'(nn_din_q[nb]), 3);
    chk("hdr_din1", 32'(nn_din_q[nb + 1]), 5);
    drain("smoke");
    chk("smoke_done_cnt", 32'(done_cnt - db), 1);

    // Upstream stall at 5 of 8, then resume
    rb = rd_addr_q.size();
    wh_wr_cnt_i = 4'd5;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (8) tick();
    chk("stall_reads", 32'(rd_addr_q.size() - rb), 5);
    chk("stall_last_addr", 32'(rd_addr_q[rb + 4]), 4);
    chk("stall_rd_en", 32'(wh_rd_en_o), 0);
    chk("stall_busy", 32'(busy_o), 1);
    wh_wr_cnt_i = 4'd8;
    settle();
    chk("resume_rd_en", 32'(wh_rd_en_o), 1);
    chk("resume_addr", 32'(wh_addr_o), 5);
    repeat (8) tick();
    chk("resume_reads", 32'(rd_addr_q.size() - rb), 8);
    chk("resume_addr7", 32'(rd_addr_q[rb + 7]), 7);
    drain("stall");

    // num_node FIFO full for 3 cycles at header entry 3
    rb = rd_addr_q.size(); nb = nn_din_q.size(); cb = nn_cyc;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (3) tick();
    tick();
    nn_ff_full_i = 1'b1;
    settle();
    chk("full0_wr", 32'(nn_ff_wr_vld_o), 1);
    chk("full0_din", 32'(nn_ff_din_o), 5);
    chk("full0_rd", 32'(wh_rd_en_o), 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      settle();
      chk("fullN_wr", 32'(nn_ff_wr_vld_o), 1);
      chk("fullN_din", 32'(nn_ff_din_o), 5);
      chk("fullN_rd", 32'(wh_rd_en_o), 0);
    end
    tick();
    nn_ff_full_i = 1'b0;
    settle();
    chk("accept_wr", 32'(nn_ff_wr_vld_o), 1);
    chk("accept_din", 32'(nn_ff_din_o), 5);
    chk("accept_rd", 32'(wh_rd_en_o), 0);
    tick();
    settle();
    chk("after_hold_wr", 32'(nn_ff_wr_vld_o), 0);
    chk("after_hold_rd", 32'(wh_rd_en_o), 1);
    chk("after_hold_addr", 32'(wh_addr_o), 4);
    repeat (6) tick();
    chk("full_wr_cycles", 32'(nn_cyc - cb), 5);
    chk("full_accepted", 32'(nn_din_q.size() - nb), 2);
    chk("full_accepted_din", 32'(nn_din_q[nb + 1]), 5);
    chk("full_reads", 32'(rd_addr_q.size() - rb), 8);
    drain("full");

    // Credit exhaustion with no pops
    rb = rd_addr_q.size();
    coef_ff_rd_i = 1'b0;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (8) tick();
    chk("credit_reads", 32'(rd_addr_q.size() - rb), 4);
    chk("credit_last_addr", 32'(rd_addr_q[rb + 3]), 3);
    chk("credit_stall_rd", 32'(wh_rd_en_o), 0);

    // Reset mid-ISSUE at rd_ptr=4
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    tick();
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk("post_reset_no_read", 32'(rd_addr_q.size() - rb), 4);
    chk("post_reset_busy", 32'(busy_o), 0);

    // Restart: full credit pool and address 0 again
    rb = rd_addr_q.size();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (8) tick();
    chk("restart_reads", 32'(rd_addr_q.size() - rb), 4);
    chk("restart_addr0", 32'(rd_addr_q[rb]), 0);
    chk("restart_addr3", 32'(rd_addr_q[rb + 3]), 3);

    // One pop returns exactly one further read
    coef_ff_rd_i = 1'b1;
    tick();
    coef_ff_rd_i = 1'b0;
    settle();
    chk("one_credit_rd", 32'(wh_rd_en_o), 1);
    chk("one_credit_addr", 32'(wh_addr_o), 4);
    tick();
    settle();
    chk("one_credit_stall", 32'(wh_rd_en_o), 0);
    repeat (3) tick();
    chk("one_credit_reads", 32'(rd_addr_q.size() - rb), 5);

    chk("total_done", 32'(done_cnt), 3);
    chk("total_vld_align", 32'(misalign), 0);

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmvm_scheduler.md
DMVM_SCHEDULER -- requirements
Module: dmvm_scheduler

Interface
REQ-001 Parameters (name, default, meaning):
- TOTAL_NODES, 13264, WH entries per run.
- NUM_NODE_WIDTH, 8, width of the per-subgraph node-count field.
- WH_WIDTH, 201, width of a WH BRAM word: bit0 = src flag, bits[NUM_NODE_WIDTH:1] = num_node.
- COEF_FF_DEPTH, 256, coef FIFO depth (credit pool).
- WH_ADDR_W, $clog2(TOTAL_NODES), WH BRAM address width.
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, single clock.
- rst_n, in, 1, asynchronous active-low reset.
- start_i, in, 1, start-run pulse.
- wh_wr_cnt_i, in, WH_ADDR_W+1, WH entries already written by upstream.
- wh_rd_en_o, out, 1, BRAM read enable.
- wh_addr_o, out, WH_ADDR_W, BRAM read address.
- wh_dout_i, in, WH_WIDTH, BRAM read data, 1-cycle latency.
- dmvm_vld_o, out, 1, DMVM input valid.
- dmvm_rdy_i, in, 1, DMVM per-coefficient done pulse.
- coef_ff_rd_i, in, 1, consumer pop from coef FIFO (returns one credit).
- nn_ff_din_o, out, NUM_NODE_WIDTH, num_node pushed per subgraph.
- nn_ff_wr_vld_o, out, 1, num_node FIFO write strobe.
- nn_ff_full_i, in, 1, num_node FIFO full.
- busy_o, out, 1, run in progress.
- done_o, out, 1, one-cycle completion pulse.

Function
REQ-003 FSM states: IDLE, ISSUE, DRAIN, DONE. Encoding is free.
REQ-004 IDLE->ISSUE on start_i; start_i is ignored in all other states.
REQ-005 ISSUE: wh_rd_en_o=1 in a cycle iff all hold:
- rd_ptr < TOTAL_NODES;
- rd_ptr < wh_wr_cnt_i;
- credit > 0;
- !nn_ff_full_i;
- no pending nn_ff write is blocked.
REQ-006 wh_addr_o=rd_ptr; rd_ptr increments on each read and never wraps within a run.
REQ-007 dmvm_vld_o = wh_rd_en_o delayed exactly one cycle, so it aligns with wh_dout_i.
REQ-008 Credit counter:
- resets to COEF_FF_DEPTH;
- -1 per read, +1 per coef_ff_rd_i;
- both in the same cycle: net 0;
- never exceeds COEF_FF_DEPTH and never underflows.
REQ-009 In a dmvm_vld_o cycle with wh_dout_i[0]=1, nn_ff_wr_vld_o=1 that cycle with nn_ff_din_o=wh_dout_i[NUM_NODE_WIDTH:1].
REQ-010 If nn_ff_full_i is high in that cycle, the write is held and retried each cycle until accepted; reads are blocked while it is held; no header is lost or duplicated.
REQ-011 ISSUE->DRAIN when rd_ptr==TOTAL_NODES.
REQ-012 DRAIN->DONE when rdy_cnt (count of dmvm_rdy_i pulses) == TOTAL_NODES.
REQ-013 DONE: done_o=1 for exactly one cycle, then IDLE; rd_ptr and rdy_cnt clear to 0. Credit is not reset, because FIFO contents persist.
REQ-014 busy_o=1 in ISSUE and DRAIN.
REQ-015 An upstream stall (wh_wr_cnt_i not advancing) holds ISSUE with no reads and no error.
REQ-016 rdy_cnt width is WH_ADDR_W+1. A dmvm_rdy_i pulse outside ISSUE/DRAIN is ignored.

Reset
REQ-017 On rst_n low, at any time including mid-run:
- state=IDLE; rd_ptr=0; rdy_cnt=0; credit=COEF_FF_DEPTH;
- all outputs 0 (wh_addr_o=0, nn_ff_din_o=0);
- the pending nn write is dropped.
REQ-018 After release, no read occurs until a new start_i.

Structure
REQ-019 The FSM state enum and the WH word field offsets (flag bit, num_node slice) belong in the shared gat package. COEF_FF_DEPTH belongs in gat_define.
REQ-020 The credit counter is a natural sub-module, credit_counter (parameter DEPTH; inc/dec/avail).
REQ-021 No other hierarchy is used. Target size is about 200 RTL lines.

Verification
REQ-022 Smoke run (TOTAL_NODES=8, wh_wr_cnt_i=8, start):
- reads at addr 0..7 in 8 consecutive cycles;
- 8 dmvm_vld_o pulses, each 1 cycle after its read;
- done_o exactly 1 cycle after the 8th dmvm_rdy_i.
REQ-023 Headers: entries 0 and 3 have flag=1 with num_node=3 and 5 -> nn_ff_wr_vld_o fires exactly twice, din=3 then 5.
REQ-024 Credit exhaustion (COEF_FF_DEPTH=4, no coef_ff_rd_i) -> exactly 4 reads, then stall. A single coef_ff_rd_i -> exactly one further read.
REQ-025 Upstream stall (wh_wr_cnt_i held at 5 of 8) -> reads stop after addr 4. Raising it to 8 resumes at addr 5.
REQ-026 nn_ff_full_i high at a header for 3 cycles -> nn_ff_wr_vld_o held for 4 cycles; no reads during the hold; one header accepted.
REQ-027 rst_n asserted mid-ISSUE at rd_ptr=4 -> next cycle all outputs 0, credit=COEF_FF_DEPTH; a new start_i restarts at addr 0.
